// File: rtl/bch_serial_encoder_pkg.sv
// Shared BCH helpers: field size from code length, generator polynomial construction and the
// encoder FSM state encoding. All functions are constant-evaluable at elaboration time.
package bch_serial_encoder_pkg;

  // State encoding kept as plain constants for compatibility with older consumers.
  typedef logic [1:0] bch_state_t;
  localparam bch_state_t StIdle   = 2'd0;
  localparam bch_state_t StData   = 2'd1;
  localparam bch_state_t StParity = 2'd2;

  // Smallest M with 2^M-1 >= n.
  function automatic int unsigned n2m(input int unsigned n);
    int unsigned m;
    m = 1;
    while (((32'd1 << m) - 1) < n) m++;
    return m;
  endfunction

  // Primitive polynomial defining GF(2^m), bit i = coefficient of x^i.
  function automatic int unsigned prim_poly(input int unsigned m);
    case (m)
      32'd2:   return 32'h7;
      32'd3:   return 32'hb;
      32'd4:   return 32'h13;
      32'd5:   return 32'h25;
      32'd6:   return 32'h43;
      32'd7:   return 32'h89;
      32'd8:   return 32'h11d;
      32'd9:   return 32'h211;
      default: return 32'h409;
    endcase
  endfunction

  // Multiply two GF(2^m) elements in polynomial basis.
  function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                         input int unsigned m);
    int unsigned p;
    int unsigned x;
    int unsigned poly;
    p    = 0;
    x    = a;
    poly = prim_poly(m);
    for (int unsigned i = 0; i < m; i++) begin
      if (b[i]) p ^= x;
      x = x << 1;
      if (x[m]) x ^= poly;
    end
    return p;
  endfunction

  // Generator polynomial of the binary narrow-sense BCH code: product of (x - alpha^e) over
  // every exponent e in the cyclotomic cosets of 1,3,..,2t-1. Taking the union of cosets gives
  // the LCM of the minimal polynomials without duplicating shared factors.
  function automatic logic [63:0] gen_poly(input int unsigned m, input int unsigned t);
    int unsigned   n;
    int unsigned   j;
    int unsigned   a;
    int unsigned   deg;
    int unsigned   prim;
    logic [1023:0] roots;
    logic [1039:0] c;      // 65 coefficients of 16 bits each, GF(2^m) valued
    logic [63:0]   g;
    n    = (32'd1 << m) - 1;
    prim = prim_poly(m);
    roots = '0;
    for (int unsigned i = 1; i < 2 * t; i += 2) begin
      j = i % n;
      for (int unsigned k = 0; k < m; k++) begin
        roots[j] = 1'b1;
        j = (2 * j) % n;
      end
    end
    c       = '0;
    c[15:0] = 16'd1;
    deg     = 0;
    a       = 1;
    for (int unsigned e = 0; e < n; e++) begin
      if (roots[e]) begin
        for (int unsigned k = deg + 1; k > 0; k--) begin
          c[k*16 +: 16] = c[(k-1)*16 +: 16] ^ 16'(gf_mul(a, 32'(c[k*16 +: 16]), m));
        end
        c[15:0] = 16'(gf_mul(a, 32'(c[15:0]), m));
        deg++;
      end
      a = a << 1;
      if (a[m]) a ^= prim;
    end
    g = '0;
    for (int unsigned k = 0; k <= deg && k < 64; k++) g[k] = c[k*16];
    return g;
  endfunction

endpackage

// File: rtl/bch_enc_lfsr.sv
// Galois LFSR computing the running remainder of m(x)*x^R modulo g(x).
// With fb_en low it degenerates to a plain left shift, used to unload the parity MSB-first.
module bch_enc_lfsr #(
  parameter int unsigned R   = 8,
  parameter logic [R-1:0] GEN = '0
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         shift,
  input  logic         fb_en,
  input  logic         din,
  output logic         msb,
  output logic [R-1:0] state
);

  logic [R-1:0] state_q;
  logic [R-1:0] state_d;
  logic         fb;

  // Next remainder: clear wins, otherwise shift with optional generator feedback.
  always_comb begin
    fb      = fb_en & (din ^ state_q[R-1]);
    state_d = state_q;
    if (clear) begin
      state_d = '0;
    end else if (shift) begin
      state_d = {state_q[R-2:0], 1'b0} ^ (fb ? GEN : '0);
    end
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign msb   = state_q[R-1];
  assign state = state_q;

endmodule

// File: rtl/bch_serial_encoder.sv
// Serial systematic BCH encoder: K message bits in MSB-first under valid/ready, N-bit codeword
// out (message then R parity bits). Optional sof/eof frame flags when BCH_ENC_FRAME_FLAGS_EN
// is defined; codeword timing is the same with or without them.
module bch_serial_encoder
  import bch_serial_encoder_pkg::*;
#(
  parameter int unsigned N = 15,
  parameter int unsigned K = 7,
  parameter int unsigned T = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din_valid,
  input  logic din,
  output logic ready,
  output logic vdout,
  output logic dout
`ifdef BCH_ENC_FRAME_FLAGS_EN
  ,
  output logic sof,
  output logic eof
`endif
);

  localparam int unsigned R  = N - K;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [63:0]   GenFull = gen_poly(n2m(N), T);
  // x^R term is implicit in the LFSR structure.
  localparam logic [R-1:0]  Gen     = GenFull[R-1:0];
  localparam logic [CW-1:0] KLast   = CW'(K - 1);
  localparam logic [CW-1:0] RLast   = CW'(R - 1);

  bch_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          vdout_q, vdout_d;
  logic          dout_q, dout_d;
  logic          accept;
  logic          in_parity;
  logic          parity_last;
  logic          lfsr_msb;
  logic [R-1:0]  unused_lfsr_state;

  assign ready       = (state_q != StParity);
  assign accept      = din_valid & ready;
  assign in_parity   = (state_q == StParity);
  assign parity_last = in_parity && (count_q == RLast);

  // Frame sequencing: counter tracks position within the current phase.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (K == 1) begin
            state_d = StParity;
            count_d = '0;
          end else begin
            state_d = StData;
            count_d = CW'(1);
          end
        end
      end
      StData: begin
        if (accept) begin
          if (count_q == KLast) begin
            state_d = StParity;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (parity_last) begin
          state_d = StIdle;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // Output stream: message bits pass through, then the remainder unloads MSB-first.
  always_comb begin
    vdout_d = 1'b0;
    dout_d  = dout_q;
    if (accept) begin
      vdout_d = 1'b1;
      dout_d  = din;
    end else if (in_parity) begin
      vdout_d = 1'b1;
      dout_d  = lfsr_msb;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      vdout_q <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vdout_q <= vdout_d;
      dout_q  <= dout_d;
    end
  end

  assign vdout = vdout_q;
  assign dout  = dout_q;

  // Clearing on the last parity shift leaves the remainder zero for the next frame.
  bch_enc_lfsr #(
    .R   (R),
    .GEN (Gen)
  ) u_lfsr (
    .clk   (clk),
    .clear (reset | parity_last),
    .shift (accept | in_parity),
    .fb_en (accept),
    .din   (din),
    .msb   (lfsr_msb),
    .state (unused_lfsr_state)
  );

`ifdef BCH_ENC_FRAME_FLAGS_EN
  logic sof_q;
  logic eof_q;

  // Frame flags registered alongside dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      sof_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      sof_q <= accept && (state_q == StIdle);
      eof_q <= parity_last;
    end
  end

  assign sof = sof_q;
  assign eof = eof_q;
`endif

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Bench for bch_serial_encoder at default N=15, K=7, T=2.
module tb_bch_serial_encoder;

  localparam int unsigned N = 15;
  localparam int unsigned K = 7;
  localparam int unsigned R = 8;
  localparam logic [8:0] GPOLY = 9'h1d1;  // x^8+x^7+x^6+x^4+1

  typedef struct {
    logic [6:0]  msg;
    logic [14:0] cw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic din_valid;
  logic din;
  logic ready;
  logic vdout;
  logic dout;
`ifdef BCH_ENC_FRAME_FLAGS_EN
  logic sof;
  logic eof;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_started = 0;
  int frames_done = 0;
  int sof_seen = 0;
  int eof_seen = 0;
  logic rx_q[$];
  int   rx_cyc[$];

  bch_serial_encoder #(
    .N (15),
    .K (7),
    .T (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .ready     (ready),
    .vdout     (vdout),
    .dout      (dout)
`ifdef BCH_ENC_FRAME_FLAGS_EN
    ,
    .sof       (sof),
    .eof       (eof)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect output bits away from the active edge.
  always @(negedge clk) begin
    if (vdout === 1'b1) begin
      rx_q.push_back(dout);
      rx_cyc.push_back(cyc);
    end
`ifdef BCH_ENC_FRAME_FLAGS_EN
    if (sof === 1'b1) sof_seen++;
    if (eof === 1'b1) eof_seen++;
`endif
  end

  // Reference: codeword = m(x)*x^R + (m(x)*x^R mod g(x)) by long division.
  function automatic logic [14:0] ref_encode(input logic [6:0] msg);
    logic [14:0] rem;
    rem = {msg, 8'b0};
    for (int i = 14; i >= 8; i--) begin
      if (rem[i]) rem ^= 15'(GPOLY) << (i - 8);
    end
    return {msg, rem[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one bit after 'gap' idle cycles; din is scrambled while ready is low.
  task automatic send_bit(input logic b, input int gap, output int waited);
    waited = 0;
    if (gap > 0) idle(gap);
    din_valid = 1'b1;
    while (!ready && waited < 100) begin
      din = 1'($urandom);
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 required ready=1 within 100 cycles");
    end
    din = b;
    @(posedge clk);
    #1;
  endtask

  // Send the first nbits of msg MSB-first; leaves din_valid high.
  task automatic send_frame(input logic [6:0] msg, input int nbits, input int gap_pos,
                            input int gap_len, input bit rand_gaps, output int first_wait);
    int w;
    int gap;
    first_wait = 0;
    for (int i = 0; i < nbits; i++) begin
      gap = (i == gap_pos) ? gap_len : 0;
      if (rand_gaps && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
      send_bit(msg[K-1-i], gap, w);
      if (i == 0) begin
        frames_started++;
        first_wait = w;
      end
    end
  endtask

  // Pull one codeword off the collected stream and compare.
  task automatic check_frame(input string name, input logic [14:0] exp, input int exp_span);
    int guard;
    int first_c;
    int last_c;
    logic [14:0] cw;
    guard = 0;
    while (rx_q.size() < N && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (rx_q.size() < N) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d bits required %0d", name, rx_q.size(), N);
      rx_q.delete();
      rx_cyc.delete();
      return;
    end
    cw = '0;
    first_c = rx_cyc[0];
    last_c = first_c;
    for (int i = 0; i < N; i++) begin
      cw = {cw[13:0], rx_q.pop_front()};
      last_c = rx_cyc.pop_front();
    end
    check({name, " codeword"}, 32'(cw), 32'(exp));
    if (exp_span >= 0) check({name, " span"}, 32'(last_c - first_c), 32'(exp_span));
    frames_done++;
  endtask

  initial begin
    vec_t vecs[4];
    int w1;
    int w2;
    logic [6:0] m1;
    logic [6:0] m2;

    vecs[0] = '{msg: 7'b1000000, cw: 15'b1000000_11101000};
    vecs[1] = '{msg: 7'b0000001, cw: 15'b0000001_11010001};
    vecs[2] = '{msg: 7'b1111111, cw: 15'h7fff};
    vecs[3] = '{msg: 7'b0000000, cw: 15'h0000};

    reset = 1'b1;
    din_valid = 1'b0;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset vdout", 32'(vdout), 0);
    check("reset dout", 32'(dout), 0);
    check("reset ready", 32'(ready), 1);
    // A bit offered while in reset must be dropped.
    din_valid = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    check("reset discard vdout", 32'(vdout), 0);
    reset = 1'b0;
    idle(3);
    check("reset no output", 32'(rx_q.size()), 0);

    // Directed table, contiguous input: exactly N consecutive output cycles.
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].msg, K, -1, 0, 1'b0, w1);
      din_valid = 1'b0;
      check_frame($sformatf("table%0d", i), vecs[i].cw, N - 1);
      idle(4);
      check($sformatf("table%0d no extra", i), 32'(rx_q.size()), 0);
    end

    // Three idle cycles between bits 2 and 3: same codeword, three-cycle hole.
    send_frame(7'b1000000, K, 2, 3, 1'b0, w1);
    din_valid = 1'b0;
    check_frame("gap", 15'b1000000_11101000, N - 1 + 3);
    idle(3);

    // din_valid held across frames: second frame waits out the R parity cycles.
    m1 = 7'($urandom);
    m2 = 7'($urandom);
    send_frame(m1, K, -1, 0, 1'b0, w1);
    send_frame(m2, K, -1, 0, 1'b0, w2);
    din_valid = 1'b0;
    check("b2b parity wait", 32'(w2), 32'(R));
    check_frame("b2b first", ref_encode(m1), N - 1);
    check_frame("b2b second", ref_encode(m2), N - 1);
    idle(3);

    // Reset after the 4th data bit abandons the frame.
    send_frame(7'b1010101, 4, -1, 0, 1'b0, w1);
    reset = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    check("midreset vdout", 32'(vdout), 0);
    check("midreset ready", 32'(ready), 1);
    reset = 1'b0;
    idle(12);
    check("midreset partial bits", 32'(rx_q.size()), 4);
    rx_q.delete();
    rx_cyc.delete();
    send_frame(7'b0000001, K, -1, 0, 1'b0, w1);
    din_valid = 1'b0;
    check_frame("after reset", 15'b0000001_11010001, N - 1);
    idle(3);

    // Random messages with random input gaps against the division model.
    for (int f = 0; f < 20; f++) begin
      m1 = 7'($urandom);
      send_frame(m1, K, -1, 0, 1'b1, w1);
      din_valid = 1'b0;
      check_frame($sformatf("rand%0d", f), ref_encode(m1), -1);
      idle($urandom_range(0, 2));
    end
    idle(4);
    check("final no extra", 32'(rx_q.size()), 0);

`ifdef BCH_ENC_FRAME_FLAGS_EN
    check("sof count", 32'(sof_seen), 32'(frames_started));
    check("eof count", 32'(eof_seen), 32'(frames_done));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
